// File: rtl/ram_fetch_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fetch_clr
//  Description : Single-clock data/instruction RAM with two ports.
//                - Fetch port: returns FETCH_BYTES consecutive words starting
//                  at fetch_addr. Addresses wrap from the top of memory to 0.
//                - Data port: performs one read or one write per cycle.
//                Both ports have registered reads with write-first
//                forwarding. A clear sequencer writes CLEAR_VAL to every word
//                after reset, or when clear_req is asserted in IDLE.
//  Ports       : clk, rst_n (async, active-low)
//                clear_req / busy          clear control and status
//                fetch_req / fetch_addr    fetch request
//                fetch_data / fetch_valid  fetch response
//                d_we / d_re / d_addr / d_wdata   data-port request
//                d_rdata / d_valid                data-port response
//                req_drop                  request discarded while busy
//  Revision    : 1.0  initial release
// ============================================================================
module ram_fetch_clr #(
    parameter int              DW          = 8,
    parameter int              AW          = 8,
    parameter int              FETCH_BYTES = 2,
    parameter logic [DW-1:0]   CLEAR_VAL   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_req,
    output logic                      busy,
    input  logic                      fetch_req,
    input  logic [AW-1:0]             fetch_addr,
    output logic [FETCH_BYTES*DW-1:0] fetch_data,
    output logic                      fetch_valid,
    input  logic                      d_we,
    input  logic                      d_re,
    input  logic [AW-1:0]             d_addr,
    input  logic [DW-1:0]             d_wdata,
    output logic [DW-1:0]             d_rdata,
    output logic                      d_valid,
    output logic                      req_drop
);

    localparam int              DEPTH       = 1 << AW;
    localparam logic [AW-1:0]   c_last_addr = '1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                      r_state;
    logic [AW-1:0]               r_clr_ptr;
    logic [DW-1:0]               mem [DEPTH];

    logic                        w_idle;
    logic                        w_any_req;
    logic                        w_we;
    logic [AW-1:0]               w_waddr;
    logic [DW-1:0]               w_wdata;
    logic [FETCH_BYTES*DW-1:0]   w_fetch_word;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_any_req = fetch_req | d_we | d_re;
    assign busy      = ~w_idle;

    // Single write port shared by the clear sequencer and the data port.
    // While clearing, port writes are discarded. During reset the state is
    // held in CLEAR with the pointer at 0, so only word 0 is (re)written.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = d_addr;
        w_wdata = d_wdata;
        if (!w_idle) begin
            w_we    = 1'b1;
            w_waddr = r_clr_ptr;
            w_wdata = CLEAR_VAL;
        end else if (d_we) begin
            w_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    // Fetch word i comes from (fetch_addr + i), with AW-bit wrap-around.
    // A same-cycle data-port write to that address is forwarded.
    generate
        for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_fetch
            logic [AW-1:0] w_addr;
            assign w_addr = fetch_addr + AW'(gi);
            assign w_fetch_word[gi*DW +: DW] =
                (d_we && (d_addr == w_addr)) ? d_wdata : mem[w_addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= '0;
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
            d_rdata     <= '0;
            d_valid     <= 1'b0;
            req_drop    <= 1'b0;
        end else begin
            req_drop <= ~w_idle & w_any_req;

            // A clear_req cycle still performs its accesses, but its valids
            // are suppressed because busy is already high when they would
            // appear.
            fetch_valid <= w_idle & fetch_req & ~clear_req;
            d_valid     <= w_idle & d_re & ~clear_req;

            if (w_idle && fetch_req) begin
                fetch_data <= w_fetch_word;
            end
            if (w_idle && d_re) begin
                d_rdata <= d_we ? d_wdata : mem[d_addr];
            end

            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == c_last_addr) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
